// File: rtl/regfile_pkg.sv
// Shared widths, FSM state encoding and requester ids for the register-file access controller.
package regfile_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned REG_W   = 32;
    localparam int unsigned NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_WB  = 2'd0,
        REQ_DEC = 2'd1,
        REQ_DBG = 2'd2
    } req_id_t;

endpackage

// File: rtl/regfile_req_arbiter.sv
// Fixed-priority arbiter (wb > dec > dbg) with debug starvation promotion.
module regfile_req_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arb_en,
    input  logic               wb_valid,
    input  logic               dec_valid,
    input  logic               dbg_valid,
    output logic [NUM_REQ-1:0] grant_c
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    // One-hot grant; debug jumps the queue once it has waited STARVE_LIMIT grants.
    always_comb begin
        grant_c = '0;
        if (arb_en) begin
            if (dbg_valid && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
                grant_c[REQ_DBG] = 1'b1;
            end else if (wb_valid) begin
                grant_c[REQ_WB] = 1'b1;
            end else if (dec_valid) begin
                grant_c[REQ_DEC] = 1'b1;
            end else if (dbg_valid) begin
                grant_c[REQ_DBG] = 1'b1;
            end
        end
    end

    // Count non-debug grants while debug waits; saturate, clear when debug is served or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!dbg_valid || grant_c[REQ_DBG]) begin
            starve_cnt <= '0;
        end else if ((grant_c[REQ_WB] || grant_c[REQ_DEC]) &&
                     (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Serialises writeback, decode and debug accesses onto the single-op register file.
module regfile_access_ctrl #(
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned REG_W        = regfile_pkg::REG_W,
    parameter int unsigned ADDR_W       = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [REG_W-1:0]  wb_val,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [ADDR_W-1:0] dec_reg_1,
    input  logic [ADDR_W-1:0] dec_reg_2,
    output logic              dec_rvalid,
    output logic [REG_W-1:0]  dec_data_1,
    output logic [REG_W-1:0]  dec_data_2,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_reg,
    input  logic [REG_W-1:0]  dbg_wval,
    output logic              dbg_rvalid,
    output logic [REG_W-1:0]  dbg_rdata,
    output logic              rf_en,
    output logic              rf_op,
    output logic [ADDR_W-1:0] rf_reg_num_1,
    output logic [ADDR_W-1:0] rf_reg_num_2,
    output logic [ADDR_W-1:0] rf_reg_num,
    output logic [REG_W-1:0]  rf_val,
    input  logic [REG_W-1:0]  rf_reg_1,
    input  logic [REG_W-1:0]  rf_reg_2
);

    import regfile_pkg::*;

    localparam int unsigned LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] grant_c;
    logic               arb_en_c;
    logic               accept_c;
    req_id_t            hold_id;
    logic               hold_we;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LAT_W-1:0]   lat_cnt_nxt;
    logic               rf_en_nxt;
    logic               dec_rvalid_nxt;
    logic               dbg_rvalid_nxt;

    req_id_t            sel_id_c;
    logic               sel_we_c;
    logic [ADDR_W-1:0]  sel_wreg_c;
    logic [REG_W-1:0]   sel_val_c;
    logic [ADDR_W-1:0]  sel_r1_c;
    logic [ADDR_W-1:0]  sel_r2_c;

    assign arb_en_c = (state == IDLE) && !rst;

    regfile_req_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (arb_en_c),
        .wb_valid  (wb_valid),
        .dec_valid (dec_valid),
        .dbg_valid (dbg_valid),
        .grant_c   (grant_c)
    );

    assign wb_ready  = grant_c[REQ_WB];
    assign dec_ready = grant_c[REQ_DEC];
    assign dbg_ready = grant_c[REQ_DBG];
    assign accept_c  = |grant_c;

    // Pick the granted requester's operation fields.
    always_comb begin
        sel_id_c   = REQ_WB;
        sel_we_c   = 1'b0;
        sel_wreg_c = '0;
        sel_val_c  = '0;
        sel_r1_c   = '0;
        sel_r2_c   = '0;
        if (grant_c[REQ_WB]) begin
            sel_id_c   = REQ_WB;
            sel_we_c   = 1'b1;
            sel_wreg_c = wb_reg;
            sel_val_c  = wb_val;
        end else if (grant_c[REQ_DEC]) begin
            sel_id_c   = REQ_DEC;
            sel_r1_c   = dec_reg_1;
            sel_r2_c   = dec_reg_2;
        end else if (grant_c[REQ_DBG]) begin
            sel_id_c   = REQ_DBG;
            sel_we_c   = dbg_we;
            sel_wreg_c = dbg_reg;
            sel_val_c  = dbg_wval;
            sel_r1_c   = dbg_reg;
            sel_r2_c   = dbg_reg;
        end
    end

    // Next-state and next-cycle strobes for the access sequencer.
    always_comb begin
        state_nxt      = state;
        lat_cnt_nxt    = lat_cnt;
        rf_en_nxt      = 1'b0;
        dec_rvalid_nxt = 1'b0;
        dbg_rvalid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = ISSUE;
                    rf_en_nxt = !(sel_we_c && (sel_wreg_c == '0));
                end
            end
            ISSUE: begin
                lat_cnt_nxt = '0;
                state_nxt   = hold_we ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                    state_nxt      = DONE;
                    dec_rvalid_nxt = (hold_id == REQ_DEC);
                    dbg_rvalid_nxt = (hold_id == REQ_DBG);
                end else begin
                    lat_cnt_nxt = lat_cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // Holding registers, register-file drive and read-data return.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_id      <= REQ_WB;
            hold_we      <= 1'b0;
            rf_en        <= 1'b0;
            rf_op        <= 1'b0;
            rf_reg_num_1 <= '0;
            rf_reg_num_2 <= '0;
            rf_reg_num   <= '0;
            rf_val       <= '0;
            dec_rvalid   <= 1'b0;
            dec_data_1   <= '0;
            dec_data_2   <= '0;
            dbg_rvalid   <= 1'b0;
            dbg_rdata    <= '0;
        end else begin
            rf_en      <= rf_en_nxt;
            dec_rvalid <= dec_rvalid_nxt;
            dbg_rvalid <= dbg_rvalid_nxt;
            if (accept_c) begin
                hold_id <= sel_id_c;
                hold_we <= sel_we_c;
            end
            // A suppressed x0 write leaves the rf_* bus untouched.
            if (accept_c && rf_en_nxt) begin
                rf_op <= sel_we_c;
                if (sel_we_c) begin
                    rf_reg_num <= sel_wreg_c;
                    rf_val     <= sel_val_c;
                end else begin
                    rf_reg_num_1 <= sel_r1_c;
                    rf_reg_num_2 <= sel_r2_c;
                end
            end
            if (dec_rvalid_nxt) begin
                dec_data_1 <= rf_reg_1;
                dec_data_2 <= rf_reg_2;
            end
            if (dbg_rvalid_nxt) begin
                dbg_rdata <= rf_reg_1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench: RD_LAT=1 controller for the main sequence plus an RD_LAT=3 instance for latency.
module tb_regfile_access_ctrl;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst;
    logic        wb_valid, dec_valid, dbg_valid, dbg_we;
    logic [4:0]  wb_reg, dec_reg_1, dec_reg_2, dbg_reg;
    logic [31:0] wb_val, dbg_wval;

    logic        wb_ready, dec_ready, dbg_ready, dec_rvalid, dbg_rvalid;
    logic [31:0] dec_data_1, dec_data_2, dbg_rdata;
    logic        rf_en, rf_op;
    logic [4:0]  rf_reg_num_1, rf_reg_num_2, rf_reg_num;
    logic [31:0] rf_val, rf_reg_1, rf_reg_2;

    logic        l3_dec_valid;
    logic        tie0;
    logic        l3_wb_ready, l3_dec_ready, l3_dbg_ready, l3_dec_rvalid, l3_dbg_rvalid;
    logic [31:0] l3_dec_data_1, l3_dec_data_2, l3_dbg_rdata;
    logic        l3_rf_en, l3_rf_op;
    logic [4:0]  l3_rf_reg_num_1, l3_rf_reg_num_2, l3_rf_reg_num;
    logic [31:0] l3_rf_val, l3_rf_reg_1, l3_rf_reg_2;

    int n_pass;
    int n_total;

    regfile_access_ctrl #(.RD_LAT(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_val(wb_val),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_reg_1(dec_reg_1), .dec_reg_2(dec_reg_2),
        .dec_rvalid(dec_rvalid), .dec_data_1(dec_data_1), .dec_data_2(dec_data_2),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_reg(dbg_reg),
        .dbg_wval(dbg_wval), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .rf_en(rf_en), .rf_op(rf_op), .rf_reg_num_1(rf_reg_num_1), .rf_reg_num_2(rf_reg_num_2),
        .rf_reg_num(rf_reg_num), .rf_val(rf_val), .rf_reg_1(rf_reg_1), .rf_reg_2(rf_reg_2)
    );

    regfile_access_ctrl #(.RD_LAT(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst(rst),
        .wb_valid(tie0), .wb_ready(l3_wb_ready), .wb_reg(wb_reg), .wb_val(wb_val),
        .dec_valid(l3_dec_valid), .dec_ready(l3_dec_ready), .dec_reg_1(dec_reg_1), .dec_reg_2(dec_reg_2),
        .dec_rvalid(l3_dec_rvalid), .dec_data_1(l3_dec_data_1), .dec_data_2(l3_dec_data_2),
        .dbg_valid(tie0), .dbg_ready(l3_dbg_ready), .dbg_we(dbg_we), .dbg_reg(dbg_reg),
        .dbg_wval(dbg_wval), .dbg_rvalid(l3_dbg_rvalid), .dbg_rdata(l3_dbg_rdata),
        .rf_en(l3_rf_en), .rf_op(l3_rf_op), .rf_reg_num_1(l3_rf_reg_num_1), .rf_reg_num_2(l3_rf_reg_num_2),
        .rf_reg_num(l3_rf_reg_num), .rf_val(l3_rf_val), .rf_reg_1(l3_rf_reg_1), .rf_reg_2(l3_rf_reg_2)
    );

    // Register-file models: read data appears exactly RD_LAT cycles after the read strobe, junk otherwise.
    logic [31:0] mem1 [32];
    logic [31:0] mem3 [32];
    logic [31:0] p1a [4];
    logic [31:0] p1b [4];
    logic [31:0] p3a [4];
    logic [31:0] p3b [4];

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem1[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
            mem3[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            p1a[i] = JUNK; p1b[i] = JUNK; p3a[i] = JUNK; p3b[i] = JUNK;
        end
    end

    always @(posedge clk) begin
        if (rf_en && rf_op) mem1[rf_reg_num] <= rf_val;
        p1a[0] <= (rf_en && !rf_op) ? mem1[rf_reg_num_1] : JUNK;
        p1b[0] <= (rf_en && !rf_op) ? mem1[rf_reg_num_2] : JUNK;
        for (int k = 1; k < 4; k++) begin
            p1a[k] <= p1a[k-1];
            p1b[k] <= p1b[k-1];
        end
    end

    always @(posedge clk) begin
        if (l3_rf_en && l3_rf_op) mem3[l3_rf_reg_num] <= l3_rf_val;
        p3a[0] <= (l3_rf_en && !l3_rf_op) ? mem3[l3_rf_reg_num_1] : JUNK;
        p3b[0] <= (l3_rf_en && !l3_rf_op) ? mem3[l3_rf_reg_num_2] : JUNK;
        for (int k = 1; k < 4; k++) begin
            p3a[k] <= p3a[k-1];
            p3b[k] <= p3b[k-1];
        end
    end

    assign rf_reg_1    = p1a[0];
    assign rf_reg_2    = p1b[0];
    assign l3_rf_reg_1 = p3a[2];
    assign l3_rf_reg_2 = p3b[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; tie0 = 1'b0;
        wb_valid = 0; wb_reg = 0; wb_val = 0;
        dec_valid = 0; dec_reg_1 = 0; dec_reg_2 = 0;
        dbg_valid = 0; dbg_we = 0; dbg_reg = 0; dbg_wval = 0;
        l3_dec_valid = 0;
        tick; tick;

        // Reset values, readies forced low while rst is high
        wb_valid = 1; #1;
        chk("rst_wb_ready", 32'(wb_ready), 0);
        chk("rst_rf_en", 32'(rf_en), 0);
        chk("rst_rf_op", 32'(rf_op), 0);
        chk("rst_dec_rvalid", 32'(dec_rvalid), 0);
        chk("rst_dec_data_1", dec_data_1, 0);
        chk("rst_rf_reg_num", 32'(rf_reg_num), 0);
        chk("rst_rf_val", rf_val, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        wb_valid = 0; rst = 0;
        tick;

        // Single write x5 then decode read (5, 0)
        wb_valid = 1; wb_reg = 5; wb_val = 32'hDEAD_BEEF; #1;
        chk("t1_wb_ready", 32'(wb_ready), 1);
        chk("t1_dec_ready_idle", 32'(dec_ready), 0);
        tick;
        wb_valid = 0; dec_valid = 1; dec_reg_1 = 5; dec_reg_2 = 0; #1;
        chk("t1_wr_rf_en", 32'(rf_en), 1);
        chk("t1_wr_rf_op", 32'(rf_op), 1);
        chk("t1_wr_rf_reg_num", 32'(rf_reg_num), 5);
        chk("t1_wr_rf_val", rf_val, 32'hDEAD_BEEF);
        chk("t1_dec_ready_issue", 32'(dec_ready), 0);
        tick; #1;
        chk("t1_dec_ready", 32'(dec_ready), 1);
        tick;
        dec_valid = 0;
        chk("t1_rd_rf_en", 32'(rf_en), 1);
        chk("t1_rd_rf_op", 32'(rf_op), 0);
        chk("t1_rd_num_1", 32'(rf_reg_num_1), 5);
        chk("t1_rd_num_2", 32'(rf_reg_num_2), 0);
        tick;
        chk("t1_wait_rvalid", 32'(dec_rvalid), 0);
        chk("t1_wait_rf_en", 32'(rf_en), 0);
        tick;
        chk("t1_rvalid", 32'(dec_rvalid), 1);
        chk("t1_data_1", dec_data_1, 32'hDEAD_BEEF);
        chk("t1_data_2", dec_data_2, 0);
        tick;
        chk("t1_rvalid_pulse", 32'(dec_rvalid), 0);
        chk("t1_data_1_held", dec_data_1, 32'hDEAD_BEEF);

        // Simultaneous wb x3=0x11, dec (3,3), dbg read x3
        wb_valid = 1; wb_reg = 3; wb_val = 32'h11;
        dec_valid = 1; dec_reg_1 = 3; dec_reg_2 = 3;
        dbg_valid = 1; dbg_we = 0; dbg_reg = 3; #1;
        chk("t2_wb_ready", 32'(wb_ready), 1);
        chk("t2_dec_ready_0", 32'(dec_ready), 0);
        chk("t2_dbg_ready_0", 32'(dbg_ready), 0);
        tick;
        wb_valid = 0;
        chk("t2_wr_rf_op", 32'(rf_op), 1);
        chk("t2_wr_rf_reg_num", 32'(rf_reg_num), 3);
        tick; #1;
        chk("t2_dec_ready", 32'(dec_ready), 1);
        chk("t2_dbg_ready_1", 32'(dbg_ready), 0);
        tick;
        dec_valid = 0;
        tick; tick;
        chk("t2_dec_rvalid", 32'(dec_rvalid), 1);
        chk("t2_dec_data_1", dec_data_1, 32'h11);
        chk("t2_dec_data_2", dec_data_2, 32'h11);
        chk("t2_dbg_ready_done", 32'(dbg_ready), 0);
        tick; #1;
        chk("t2_dbg_ready", 32'(dbg_ready), 1);
        tick;
        dbg_valid = 0;
        chk("t2_dbg_rf_en", 32'(rf_en), 1);
        chk("t2_dbg_rf_op", 32'(rf_op), 0);
        chk("t2_dbg_num_1", 32'(rf_reg_num_1), 3);
        chk("t2_dbg_num_2", 32'(rf_reg_num_2), 3);
        tick; tick;
        chk("t2_dbg_rvalid", 32'(dbg_rvalid), 1);
        chk("t2_dbg_rdata", dbg_rdata, 32'h11);
        chk("t2_dec_rvalid_quiet", 32'(dec_rvalid), 0);
        tick;
        chk("t2_dbg_rvalid_pulse", 32'(dbg_rvalid), 0);

        // x0 write accepted but never strobed; later read returns 0
        wb_valid = 1; wb_reg = 0; wb_val = 32'hFFFF_FFFF; #1;
        chk("t3_wb_ready", 32'(wb_ready), 1);
        tick;
        wb_valid = 0;
        chk("t3_rf_en_x0", 32'(rf_en), 0);
        chk("t3_rf_reg_num_held", 32'(rf_reg_num), 3);
        chk("t3_rf_val_held", rf_val, 32'h11);
        tick;
        dec_valid = 1; dec_reg_1 = 0; dec_reg_2 = 5; #1;
        chk("t3_dec_ready", 32'(dec_ready), 1);
        tick;
        dec_valid = 0;
        tick; tick;
        chk("t3_dec_rvalid", 32'(dec_rvalid), 1);
        chk("t3_data_x0", dec_data_1, 0);
        chk("t3_data_x5", dec_data_2, 32'hDEAD_BEEF);
        tick;

        // Starvation: debug write x7 waits behind four wb writes, then wins
        dbg_valid = 1; dbg_we = 1; dbg_reg = 7; dbg_wval = 32'h77;
        wb_valid = 1; wb_reg = 10; wb_val = 32'h100;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_wb_ready", 32'(wb_ready), 1);
            chk("t4_dbg_wait", 32'(dbg_ready), 0);
            tick;
            chk("t4_wb_issue_num", 32'(rf_reg_num), 32'(10 + i));
            wb_reg = 5'(11 + i); wb_val = 32'h101 + 32'(i);
            tick;
        end
        #1;
        chk("t4_dbg_promoted", 32'(dbg_ready), 1);
        chk("t4_wb_blocked", 32'(wb_ready), 0);
        tick;
        chk("t4_dbg_rf_en", 32'(rf_en), 1);
        chk("t4_dbg_rf_op", 32'(rf_op), 1);
        chk("t4_dbg_rf_reg_num", 32'(rf_reg_num), 7);
        chk("t4_dbg_rf_val", rf_val, 32'h77);
        tick; #1;
        chk("t4_cnt_cleared_wb", 32'(wb_ready), 1);
        chk("t4_cnt_cleared_dbg", 32'(dbg_ready), 0);
        tick;
        wb_valid = 0; dbg_valid = 0;
        chk("t4_wb5_num", 32'(rf_reg_num), 14);
        tick;

        // Reset during RD_WAIT drops the read
        dec_valid = 1; dec_reg_1 = 7; dec_reg_2 = 10; #1;
        chk("t5_dec_ready", 32'(dec_ready), 1);
        tick;
        dec_valid = 0;
        tick;
        rst = 1;
        tick;
        dec_valid = 1; #1;
        chk("t5_no_rvalid", 32'(dec_rvalid), 0);
        chk("t5_rf_en", 32'(rf_en), 0);
        chk("t5_rf_num_1", 32'(rf_reg_num_1), 0);
        chk("t5_rf_val", rf_val, 0);
        chk("t5_data_1", dec_data_1, 0);
        chk("t5_ready_in_rst", 32'(dec_ready), 0);
        rst = 0; #1;
        chk("t5_ready_after_rst", 32'(dec_ready), 1);
        tick;
        dec_valid = 0;
        chk("t5_rf_en_new", 32'(rf_en), 1);
        chk("t5_num_1_new", 32'(rf_reg_num_1), 7);
        chk("t5_num_2_new", 32'(rf_reg_num_2), 10);
        tick;
        chk("t5_wait_rvalid", 32'(dec_rvalid), 0);
        tick;
        chk("t5_rvalid", 32'(dec_rvalid), 1);
        chk("t5_data_x7", dec_data_1, 32'h77);
        chk("t5_data_x10", dec_data_2, 32'h100);
        tick;

        // RD_LAT=3 instance: rvalid exactly 5 cycles after acceptance, readies low meanwhile
        dec_reg_1 = 5; dec_reg_2 = 0; l3_dec_valid = 1; #1;
        chk("t6_l3_dec_ready", 32'(l3_dec_ready), 1);
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk("t6_l3_ready_low", 32'(l3_dec_ready), 0);
            chk("t6_l3_rvalid", 32'(l3_dec_rvalid), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                l3_dec_valid = 0;
                chk("t6_l3_data_1", l3_dec_data_1, 32'h1000_0005);
                chk("t6_l3_data_2", l3_dec_data_2, 0);
            end
        end
        tick;
        chk("t6_l3_rvalid_pulse", 32'(l3_dec_rvalid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
